// File: rtl/vdp_video_out_ctrl.sv
// vdp_video_out_ctrl: shadow/commit controller for vdp_video_out.
// Host writes land in shadow registers.  A serial restoring divider derives
// normalize = floor((32768 + d/2) / d), saturated to 255, from the shadow
// denominator.  All three shadows are copied to the outputs together at one
// raster position per frame, and only while the divider is idle, so that
// denominator and normalize never disagree on the outputs.
//
// state | meaning
// IDLE  | divider idle, sh_norm matches sh_den
// DIV   | 17-cycle restoring division, one quotient bit per clock
// SAT   | divisor is zero, sh_norm forced to 255 for one cycle
module vdp_video_out_ctrl #(
    parameter logic [10:0] COMMIT_H = 11'd0,
    parameter logic [9:0]  COMMIT_V = 10'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        wr_req,
    input  logic [1:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic        busy,
    output logic        pending,
    output logic [7:0]  reg_denominator,
    output logic [7:0]  reg_normalize,
    output logic        reg_scanline
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_SAT  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        wr_ack_q;
    logic        pending_q;
    logic [7:0]  sh_den_q;
    logic [7:0]  sh_norm_q;
    logic        sh_scan_q;
    logic [7:0]  den_q;
    logic [7:0]  norm_q;
    logic        scan_q;

    logic [16:0] dvd_q;
    logic [16:0] quot_q;
    logic [7:0]  rem_q;
    logic [4:0]  cnt_q;

    logic        wr_acc;
    logic        wr_den;
    logic        wr_scan;
    logic        at_commit;
    logic        do_commit;
    logic        busy_w;
    logic        div_fin;
    logic        sat_fin;
    logic        div_last;
    logic [8:0]  trial;
    logic        trial_ge;
    logic [7:0]  diff;
    logic [16:0] quot_nxt;

    // A request is only taken when no acknowledge is in flight, which limits
    // the host to one write every two cycles.
    assign wr_acc    = wr_req & ~wr_ack_q;
    assign wr_den    = wr_acc & (wr_addr == 2'd0);
    assign wr_scan   = wr_acc & (wr_addr == 2'd1);
    assign at_commit = (h_count == COMMIT_H) && (v_count == COMMIT_V);
    // Commit is judged on pre-edge busy, so a division ending on the commit
    // edge still defers the whole commit by a frame.
    assign do_commit = at_commit & pending_q & ~busy_w;

    // Remainder is always below the divisor (<= 255), so 8 bits hold it and
    // the 9-bit trial only needs its low byte after subtraction.
    assign trial     = {rem_q, dvd_q[16]};
    assign trial_ge  = (trial >= {1'b0, sh_den_q});
    assign diff      = trial[7:0] - sh_den_q;
    assign quot_nxt  = {quot_q[15:0], trial_ge};
    assign div_last  = (cnt_q == 5'd16);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: a denominator write always (re)starts the divider.
    always_comb begin
        state_d = state_q;
        if (wr_den) begin
            state_d = (wr_data == 8'd0) ? S_SAT : S_DIV;
        end else begin
            case (state_q)
                S_DIV:   if (div_last) state_d = S_IDLE;
                S_SAT:   state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // FSM outputs: busy flag and the cycles that deliver a normalize result.
    always_comb begin
        busy_w  = (state_q != S_IDLE);
        div_fin = (state_q == S_DIV) && div_last && !wr_den;
        sat_fin = (state_q == S_SAT) && !wr_den;
    end

    // Handshake acknowledge and pending flag; a write beats a same-edge commit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ack_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            wr_ack_q <= wr_acc;
            if (wr_den || wr_scan) pending_q <= 1'b1;
            else if (do_commit)    pending_q <= 1'b0;
        end
    end

    // Divider datapath: load dividend on a denominator write, then shift.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dvd_q  <= 17'd0;
            quot_q <= 17'd0;
            rem_q  <= 8'd0;
            cnt_q  <= 5'd0;
        end else if (wr_den) begin
            dvd_q  <= 17'h08000 + {10'd0, wr_data[7:1]};
            quot_q <= 17'd0;
            rem_q  <= 8'd0;
            cnt_q  <= 5'd0;
        end else if (state_q == S_DIV) begin
            dvd_q  <= {dvd_q[15:0], 1'b0};
            quot_q <= quot_nxt;
            rem_q  <= trial_ge ? diff : trial[7:0];
            cnt_q  <= cnt_q + 5'd1;
        end
    end

    // Shadow registers; sh_norm only changes when a division completes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_den_q  <= 8'd144;
            sh_norm_q <= 8'd228;
            sh_scan_q <= 1'b0;
        end else begin
            if (wr_den)  sh_den_q  <= wr_data;
            if (wr_scan) sh_scan_q <= wr_data[0];
            if (div_fin) sh_norm_q <= (quot_nxt[16:8] != 9'd0) ? 8'd255 : quot_nxt[7:0];
            if (sat_fin) sh_norm_q <= 8'd255;
        end
    end

    // Committed outputs: all three copied together at the commit position.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            den_q  <= 8'd144;
            norm_q <= 8'd228;
            scan_q <= 1'b0;
        end else if (do_commit) begin
            den_q  <= sh_den_q;
            norm_q <= sh_norm_q;
            scan_q <= sh_scan_q;
        end
    end

    assign wr_ack          = wr_ack_q;
    assign busy            = busy_w;
    assign pending         = pending_q;
    assign reg_denominator = den_q;
    assign reg_normalize   = norm_q;
    assign reg_scanline    = scan_q;

endmodule

// File: tb/tb_vdp_video_out_ctrl.sv
// Testbench for vdp_video_out_ctrl: directed scenarios followed by random
// host traffic, every cycle checked against a transaction-level model.
module tb_vdp_video_out_ctrl;

    localparam int H_TOT = 16;
    localparam int V_TOT = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        wr_req;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        busy;
    logic        pending;
    logic [7:0]  reg_denominator;
    logic [7:0]  reg_normalize;
    logic        reg_scanline;

    int h = 0;
    int v = 0;
    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit m_ack;
    int m_busy;
    bit m_pend;
    int m_sh_den;
    bit m_sh_scan;
    int m_den;
    int m_norm;
    bit m_scan;

    always #5 clk = ~clk;

    vdp_video_out_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .h_count         (h_count),
        .v_count         (v_count),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .busy            (busy),
        .pending         (pending),
        .reg_denominator (reg_denominator),
        .reg_normalize   (reg_normalize),
        .reg_scanline    (reg_scanline)
    );

    function automatic int norm_of(input int d);
        int q;
        if (d == 0) return 255;
        q = (32768 + d / 2) / d;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ack     = 1'b0;
        m_busy    = 0;
        m_pend    = 1'b0;
        m_sh_den  = 144;
        m_sh_scan = 1'b0;
        m_den     = 144;
        m_norm    = 228;
        m_scan    = 1'b0;
    endtask

    // One clock: advance the model with the inputs presented at this edge,
    // then compare every DUT output and move the raster on.
    task automatic step();
        bit acc;
        if (!reset_n) begin
            model_reset();
        end else begin
            acc = wr_req && !m_ack;
            if (h == 0 && v == 0 && m_pend && m_busy == 0) begin
                m_den  = m_sh_den;
                m_norm = norm_of(m_sh_den);
                m_scan = m_sh_scan;
                m_pend = 1'b0;
            end
            if (acc && wr_addr == 2'd0) begin
                m_sh_den = int'(wr_data);
                m_busy   = (wr_data == 8'd0) ? 1 : 17;
                m_pend   = 1'b1;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            if (acc && wr_addr == 2'd1) begin
                m_sh_scan = wr_data[0];
                m_pend    = 1'b1;
            end
            m_ack = acc;
        end
        @(posedge clk);
        #1;
        chk("wr_ack",  32'(wr_ack),          32'(m_ack));
        chk("busy",    32'(busy),            32'(m_busy > 0));
        chk("pending", 32'(pending),         32'(m_pend));
        chk("reg_den", 32'(reg_denominator), 32'(m_den));
        chk("reg_norm",32'(reg_normalize),   32'(m_norm));
        chk("reg_scan",32'(reg_scanline),    32'(m_scan));
        h++;
        if (h == H_TOT) begin
            h = 0;
            v = (v == V_TOT - 1) ? 0 : v + 1;
        end
        h_count = 11'(h);
        v_count = 10'(v);
    endtask

    task automatic run_until(input int hh, input int vv);
        int  n = 0;
        bit  found;
        while (!(h == hh && v == vv) && n < 2 * H_TOT * V_TOT) begin
            step();
            n++;
        end
        found = (h == hh && v == vv);
        n_cmp++;
        assert (found) else begin
            n_bad++;
            $error("FAIL raster_wait: observed h=%0d v=%0d expected h=%0d v=%0d", h, v, hh, vv);
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [7:0] d, input bit hold);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        if (hold) step();
        wr_req = 1'b0;
    endtask

    task automatic count_busy(input string tag, input int exp_len);
        int cnt;
        cnt = busy ? 1 : 0;
        repeat (19) begin
            step();
            if (busy) cnt++;
        end
        chk(tag, 32'(cnt), 32'(exp_len));
    endtask

    initial begin
        int  gap;
        int  sel;
        logic [1:0] ra;
        logic [7:0] rd;
        bit  p_before;

        reset_n = 1'b0;
        wr_req  = 1'b0;
        wr_addr = 2'd0;
        wr_data = 8'd0;
        h_count = 11'd0;
        v_count = 10'd0;
        model_reset();
        #1;
        step();
        step();
        reset_n = 1'b1;

        // reset values, then a full idle frame
        chk("rst_den",  32'(reg_denominator), 32'd144);
        chk("rst_norm", 32'(reg_normalize),   32'd228);
        chk("rst_scan", 32'(reg_scanline),    32'd0);
        repeat (H_TOT * V_TOT) step();
        chk("idle_pend", 32'(pending), 32'd0);
        chk("idle_den",  32'(reg_denominator), 32'd144);

        // single division committed at the next frame start
        run_until(0, 5);
        host_write(2'd0, 8'd200, 1'b0);
        count_busy("busy_len_200", 17);
        run_until(0, 0);
        step();
        chk("c200_den",  32'(reg_denominator), 32'd200);
        chk("c200_norm", 32'(reg_normalize),   32'd164);
        chk("c200_pend", 32'(pending),         32'd0);

        // restart mid-division
        run_until(0, 2);
        host_write(2'd0, 8'd200, 1'b0);
        step();
        step();
        host_write(2'd0, 8'd255, 1'b0);
        count_busy("busy_len_restart", 17);
        run_until(0, 0);
        step();
        chk("c255_den",  32'(reg_denominator), 32'd255);
        chk("c255_norm", 32'(reg_normalize),   32'd129);

        // divider overlapping the commit point defers a whole frame
        run_until(H_TOT - 10, V_TOT - 1);
        host_write(2'd0, 8'd150, 1'b0);
        run_until(0, 0);
        step();
        chk("defer_den",  32'(reg_denominator), 32'd255);
        chk("defer_pend", 32'(pending),         32'd1);
        run_until(0, 0);
        step();
        chk("c150_den",  32'(reg_denominator), 32'd150);
        chk("c150_norm", 32'(reg_normalize),   32'd218);
        chk("c150_pend", 32'(pending),         32'd0);

        // scanline, zero divisor, reserved address
        run_until(0, 3);
        host_write(2'd1, 8'd1, 1'b0);
        step();
        host_write(2'd0, 8'd0, 1'b0);
        step();
        step();
        p_before = pending;
        host_write(2'd3, 8'hAA, 1'b1);
        chk("ack_addr3",  32'(wr_ack) | 32'(m_ack), 32'd0);
        chk("pend_addr3", 32'(pending), 32'(p_before));
        run_until(0, 0);
        step();
        chk("c0_scan", 32'(reg_scanline),    32'd1);
        chk("c0_den",  32'(reg_denominator), 32'd0);
        chk("c0_norm", 32'(reg_normalize),   32'd255);

        // reset during a division
        run_until(0, 3);
        host_write(2'd0, 8'd77, 1'b0);
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_rst_den",  32'(reg_denominator), 32'd144);
        chk("mid_rst_norm", 32'(reg_normalize),   32'd228);
        chk("mid_rst_busy", 32'(busy),            32'd0);
        chk("mid_rst_pend", 32'(pending),         32'd0);
        run_until(0, 0);
        step();
        chk("post_rst_den", 32'(reg_denominator), 32'd144);

        // random host traffic
        repeat (60) begin
            gap = $urandom_range(0, 30);
            repeat (gap) step();
            ra  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            if (sel == 0)      rd = 8'd0;
            else if (sel == 1) rd = 8'($urandom_range(1, 128));
            else               rd = 8'($urandom_range(129, 255));
            host_write(ra, rd, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                step();
                reset_n = 1'b1;
            end
        end
        repeat (3 * H_TOT * V_TOT) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vdp_video_out_ctrl.md
# vdp_video_out_ctrl

Configuration controller for `vdp_video_out`. It accepts host register writes for the denominator and the scanline enable, and computes the matching normalize value with a serial divider. It commits all three parameters to `vdp_video_out` together, at one raster position per frame, so they never change mid-frame. It sits between the VDP register file and `vdp_video_out`, driving that block's `reg_denominator`, `reg_normalize` and `reg_scanline` inputs.

## Interface
Parameters:
- `COMMIT_H`, default 0: h_count value at which a pending commit is applied.
- `COMMIT_V`, default 0: v_count value at which a pending commit is applied.

Ports:
- `clk`  in  1  single clock; all logic runs on its rising edge.
- `reset_n`  in  1  synchronous reset, active-low.
- `h_count`  in  11  horizontal raster counter, shared with `vdp_video_out`.
- `v_count`  in  10  vertical raster counter, shared with `vdp_video_out`.
- `wr_req`  in  1  host write request; held high until `wr_ack`.
- `wr_addr`  in  2  register address: 0 = denominator, 1 = scanline (bit0), 2 and 3 = reserved.
- `wr_data`  in  8  write data.
- `wr_ack`  out  1  one-cycle acknowledge pulse.
- `busy`  out  1  divider running.
- `pending`  out  1  shadow values are not yet committed.
- `reg_denominator`  out  8  committed denominator.
- `reg_normalize`  out  8  committed normalize value.
- `reg_scanline`  out  1  committed scanline enable.

## Operation
- Shadow registers: `sh_den`, `sh_norm`, `sh_scan`. Committed outputs are copies of the shadows.
- Normalize rule: `norm = floor((32768 + floor(d/2)) / d)`, saturated to 255.
  - d = 0 gives 255.
  - d ≤ 128 gives 255.
  - d = 144 gives 228.
  - d = 200 gives 164.
  - d = 255 gives 129.
- Divider: restoring division, 17-bit dividend, 8-bit divisor, one quotient bit per clock.
- Divider FSM: IDLE → DIV (17 cycles) → IDLE, writing `sh_norm` at the end of DIV.
  - d = 0 takes IDLE → SAT (1 cycle, `sh_norm` = 255) → IDLE.
  - `busy` is high in DIV and SAT.
- Host writes:
  - A write to addr 0 loads `sh_den`, sets `pending`, and (re)starts the divider.
  - A write to addr 0 while the divider is in DIV aborts the current division and restarts it with the new divisor.
  - A write to addr 1 loads `sh_scan` = `wr_data[0]` and sets `pending`.
  - Writes to addr 2 and 3 are acknowledged and ignored; `pending` is unchanged.
- Commit point: the edge at which `h_count == COMMIT_H` and `v_count == COMMIT_V` are sampled.
  - If `pending` and not `busy`: all three outputs load from the shadows and `pending` clears.
  - If `busy`: the whole commit is deferred to the next frame's commit point. Denominator and normalize are therefore never mismatched on the outputs.
  - If no commit is pending: outputs hold.

## Timing
- Reset (`reset_n` low, sampled at an edge):
  - `reg_denominator` = 144, `reg_normalize` = 228, `reg_scanline` = 0.
  - Shadows take the same values.
  - `wr_ack` = 0, `busy` = 0, `pending` = 0, FSM = IDLE.
  - Reset mid-division aborts the division with no shadow update.
- Handshake:
  - The edge that samples `wr_req` = 1 with `wr_ack` = 0 updates the shadow; `wr_ack` = 1 during the following cycle.
  - `wr_req` is ignored in any cycle where `wr_ack` = 1.
  - Maximum rate is one write per 2 cycles.
- Divider latency:
  - `busy` rises in the cycle after the write edge and stays high for 17 cycles (1 cycle for d = 0).
  - `sh_norm` is valid in the cycle `busy` falls.
- Commit latency: outputs change in the cycle after the commit edge.
- Write and commit on the same edge:
  - The commit uses the pre-edge shadows and pre-edge `busy`.
  - The new write leaves `pending` = 1 for the next frame.
- Divider finishing on the commit edge: `busy` is still high at that edge, so the commit is deferred.

## Test plan
- Reset, then idle for one frame: outputs stay 144/228/0, and `pending`/`busy` stay 0.
- Write addr 0 = 200 at v = 5 → `busy` high for exactly 17 cycles. At the next (0,0): `reg_denominator` = 200 and `reg_normalize` = 164, both updated in the same cycle; `pending` clears.
- Write addr 0 = 200, then 3 cycles later write addr 0 = 255 → the division restarts and `busy` stays high for 17 cycles after the second write. The commit gives 255/129; 164 never appears on the outputs.
- Write addr 0 = 150 so that `busy` overlaps the commit point → no output change that frame. The next frame commits 150/218; `pending` stays 1 across the skipped frame.
- Write addr 1 = 1, and addr 0 = 0 → the commit gives `reg_scanline` = 1, 0/255. A write to addr 3 is acknowledged with `pending` unchanged.
- Assert `reset_n` low during DIV with `pending` = 1 → the next cycle shows defaults, and no commit occurs at the following (0,0).
